memory: RTL and testbench



---
 rtl/memory.sv | 51 +++++
 tb/tb_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// memory: single-port synchronous RAM, DEPTH words x DATA_WIDTH bits.
//
// One shared address serves both writes and reads. A read is registered:
// addr/rd_en sampled at a rising edge appear on data_out after that edge.
// When wr_en and rd_en are both high, data_out receives the old word
// (read-before-write) and the new word is stored for later reads.
// An asynchronous active-low reset clears every word and data_out.
//
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write enable, active high
//   reset    in   asynchronous reset, active low
//   rd_en    in   read enable, active high
//   addr     in   [ADDR_WIDTH-1:0] shared read/write word address
//   data_in  in   [DATA_WIDTH-1:0] write data
//   data_out out  [DATA_WIDTH-1:0] registered read data (holds when rd_en=0)
module memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage and output register share one process so that the read sees
  // the pre-edge contents of mem[addr] even when a write hits the same word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      data_out <= '0;
    end else begin
      if (wr_en) begin
        mem[addr] <= data_in;
      end
      if (rd_en) begin
        data_out <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
module tb_memory;

  logic       clk;
  logic       wr_en;
  logic       reset;
  logic       rd_en;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] held;

  memory #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .wr_en(wr_en),
    .reset(reset),
    .rd_en(rd_en),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle: inputs change on the falling edge, outputs are
  // observed 1 ns after the rising edge. Reads push the model's pre-edge
  // word (read-before-write) into the scoreboard.
  task automatic cycle(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; data_in = d;
    if (r) exp_q.push_back(model[a]);
    if (w) model[a] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] exp;
    reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1; addr = 4'd2; data_in = 8'hFF;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    #10;
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out: got %h expected 00", data_out);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp || exp !== 8'h00) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected %h", i, data_out, exp);
      end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] exp;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 8'h00);
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL write_read[%0d]: scoreboard empty", i);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (data_out !== exp) begin
          errors++;
          $display("FAIL write_read[%0d]: got %h expected %h", i, data_out, exp);
        end
      end
    end
  endtask

  task automatic test_hold;
    cycle(1'b1, 1'b0, 4'd3, 8'hA5);
    cycle(1'b0, 1'b1, 4'd3, 8'h00);
    held = exp_q.pop_front();
    checks++;
    if (data_out !== held || held !== 8'hA5) begin
      errors++;
      $display("FAIL hold_read: got %h expected A5", data_out);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 4'd7, 8'h5A);
      checks++;
      if (data_out !== held) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got %h expected %h", i, data_out, held);
      end
    end
  endtask

  task automatic test_read_before_write;
    logic [7:0] exp;
    cycle(1'b1, 1'b0, 4'd5, 8'h11);
    cycle(1'b1, 1'b1, 4'd5, 8'h22);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp || exp !== 8'h11) begin
      errors++;
      $display("FAIL rbw_old: got %h expected 11", data_out);
    end
    cycle(1'b0, 1'b1, 4'd5, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp || exp !== 8'h22) begin
      errors++;
      $display("FAIL rbw_new: got %h expected 22", data_out);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'(i), 8'hFF);
    cycle(1'b0, 1'b1, 4'd9, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("FAIL async_pre: got %h expected %h", data_out, exp);
    end
    // Pulse reset entirely inside the high phase, away from any edge.
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_immediate: got %h expected 00", data_out);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp || exp !== 8'h00) begin
        errors++;
        $display("FAIL async_read[%0d]: got %h expected 00", i, data_out);
      end
    end
  endtask

  task automatic test_boundary;
    logic [7:0] exp;
    cycle(1'b1, 1'b0, 4'd0, 8'h01);
    cycle(1'b1, 1'b0, 4'd15, 8'h80);
    cycle(1'b0, 1'b1, 4'd0, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp || exp !== 8'h01) begin
      errors++;
      $display("FAIL boundary_addr0: got %h expected 01", data_out);
    end
    cycle(1'b0, 1'b1, 4'd15, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp || exp !== 8'h80) begin
      errors++;
      $display("FAIL boundary_addr15: got %h expected 80", data_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    // Write then immediately read the same address on the next cycle,
    // interleaved across several addresses.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 4'(i + 8), 8'(8'h30 + i * 7));
      cycle(1'b0, 1'b1, 4'(i + 8), 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL wr_then_rd[%0d]: got %h expected %h", i, data_out, exp);
      end
    end
    cycle(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; data_in = '0; reset = 1'b0;
    test_reset();
    test_write_read();
    test_hold();
    test_read_before_write();
    test_boundary();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
